// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared types and constants for the instruction-fetch slice.
//   addr_t / inst_t   : 32-bit address and instruction buses
//   RESET_PC_DEFAULT  : default PC loaded on reset
//   NOP_INST          : bubble instruction word (sll $0,$0,0)
//   state_t           : fetch FSM encoding (ST_RESET=0, ST_RUN=1)
package fetch_unit_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] inst_t;

    localparam addr_t       RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam inst_t       NOP_INST          = 32'h0000_0000;
    localparam int unsigned ROM_BYTES_DEFAULT = 512;

    typedef enum logic {
        ST_RESET = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch stage's control inputs, the instruction
// ROM bus and the IF/ID outputs toward decode.
//   master : the fetch unit (drives ROM enable/address and IF/ID outputs)
//   slave  : the surrounding pipeline/ROM (drives stalls, branch, flush, rom_inst)
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    // pipeline control
    logic  stall_if;
    logic  stall_id;
    logic  branch_flag;
    addr_t branch_target;
    logic  flush;
    addr_t flush_pc;

    // instruction ROM
    logic  rom_en;
    addr_t rom_addr;
    inst_t rom_inst;

    // IF/ID register toward decode
    addr_t id_pc;
    inst_t id_inst;
    logic  id_valid;
    logic  fetch_err;

    modport master (
        input  stall_if, stall_id, branch_flag, branch_target, flush, flush_pc,
        input  rom_inst,
        output rom_en, rom_addr,
        output id_pc, id_inst, id_valid, fetch_err
    );

    modport slave (
        output stall_if, stall_id, branch_flag, branch_target, flush, flush_pc,
        output rom_inst,
        input  rom_en, rom_addr,
        input  id_pc, id_inst, id_valid, fetch_err
    );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with bubble / hold / latch control.
//   clk, rst   : clock, synchronous active-high reset
//   run        : fetch FSM is in ST_RUN
//   flush      : exception/eret flush (forces a bubble)
//   stall_if   : fetch stalled (bubble unless decode also stalled)
//   stall_id   : decode stalled (hold contents)
//   pc, inst   : address and ROM word fetched this cycle
//   err        : this cycle's fetch address is misaligned or out of range
//   id_*       : registered outputs toward decode
module if_id_reg import fetch_unit_pkg::*; #(
    parameter inst_t NOP_INST = fetch_unit_pkg::NOP_INST
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  run,
    input  logic  flush,
    input  logic  stall_if,
    input  logic  stall_id,
    input  addr_t pc,
    input  inst_t inst,
    input  logic  err,
    output addr_t id_pc,
    output inst_t id_inst,
    output logic  id_valid,
    output logic  fetch_err
);

    // A bubble keeps id_pc so decode still knows where the slot sits; only
    // reset clears it. An erroring fetch is kept valid but carries a NOP so
    // decode raises AdEL without executing whatever the ROM returned.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_pc     <= '0;
            id_inst   <= NOP_INST;
            id_valid  <= 1'b0;
            fetch_err <= 1'b0;
        end else if (!run || flush || (stall_if && !stall_id)) begin
            id_inst   <= NOP_INST;
            id_valid  <= 1'b0;
            fetch_err <= 1'b0;
        end else if (!stall_id) begin
            id_pc     <= pc;
            id_inst   <= err ? NOP_INST : inst;
            id_valid  <= 1'b1;
            fetch_err <= err;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction-fetch stage. Owns the PC, drives the ROM,
// and captures the zero-latency ROM word into the IF/ID register.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_unit_if.master -- stall/branch/flush inputs, ROM bus
//              (rom_en, rom_addr, rom_inst) and IF/ID outputs
//              (id_pc, id_inst, id_valid, fetch_err)
// Parameters: RESET_PC, ROM_BYTES (fetches at/above are errors), NOP_INST.
module fetch_unit import fetch_unit_pkg::*; #(
    parameter addr_t       RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned ROM_BYTES = ROM_BYTES_DEFAULT,
    parameter inst_t       NOP_INST  = fetch_unit_pkg::NOP_INST
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    localparam addr_t ROM_LIMIT = addr_t'(ROM_BYTES);

    function automatic logic addr_err(input addr_t a);
        return (a[1:0] != 2'b00) || (a >= ROM_LIMIT);
    endfunction

    state_t state_q;
    state_t state_d;
    logic   run;
    addr_t  pc_p0;
    logic   err_now;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RESET;
        else     state_q <= state_d;
    end

    // FSM next state: leave reset one edge after rst drops, then stay running
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_RESET;
        endcase
    end

    // FSM outputs
    always_comb begin
        run        = (state_q == ST_RUN);
        bus.rom_en = run;
    end

    // PC: flush beats stall beats branch beats sequential. A branch seen
    // while stalled is dropped; ID keeps branch_flag up until the stall ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0 <= RESET_PC;
        end else if (run) begin
            if (bus.flush)            pc_p0 <= bus.flush_pc;
            else if (bus.stall_if)    pc_p0 <= pc_p0;
            else if (bus.branch_flag) pc_p0 <= bus.branch_target;
            else                      pc_p0 <= pc_p0 + 32'd4;
        end
    end

    assign bus.rom_addr = pc_p0;
    assign err_now      = addr_err(pc_p0);

    // IF -> ID stage boundary
    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .flush     (bus.flush),
        .stall_if  (bus.stall_if),
        .stall_id  (bus.stall_id),
        .pc        (pc_p0),
        .inst      (bus.rom_inst),
        .err       (err_now),
        .id_pc     (bus.id_pc),
        .id_inst   (bus.id_inst),
        .id_valid  (bus.id_valid),
        .fetch_err (bus.fetch_err)
    );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    typedef struct {
        logic        r;
        logic        sif;
        logic        sid;
        logic        br;
        logic [31:0] bt;
        logic        fl;
        logic [31:0] fp;
        logic        en;
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] iinst;
        logic        iv;
        logic        ie;
    } vec_t;

    localparam logic [31:0] N = 32'h0000_0000;

    logic clk;
    logic rst;
    fetch_unit_if bus();

    int total  = 0;
    int passed = 0;
    vec_t vecs[$];

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .ROM_BYTES (512),
        .NOP_INST  (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ROM model: every word encodes its own address so the source is visible
    assign bus.rom_inst = 32'h1000_0000 | bus.rom_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rv(input logic [31:0] a);
        return 32'h1000_0000 | a;
    endfunction

    task automatic add(input logic r, input logic sif, input logic sid, input logic br,
                       input logic [31:0] bt, input logic fl, input logic [31:0] fp,
                       input logic en, input logic [31:0] pc, input logic [31:0] ipc,
                       input logic [31:0] iinst, input logic iv, input logic ie);
        vec_t v;
        v.r = r; v.sif = sif; v.sid = sid; v.br = br; v.bt = bt; v.fl = fl; v.fp = fp;
        v.en = en; v.pc = pc; v.ipc = ipc; v.iinst = iinst; v.iv = iv; v.ie = ie;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s step %0d: got %h expected %h", nm, row, act, exp);
        else
            passed++;
    endtask

    task automatic drive(input logic r, input logic sif, input logic sid, input logic br,
                         input logic [31:0] bt, input logic fl, input logic [31:0] fp);
        rst               = r;
        bus.stall_if      = sif;
        bus.stall_id      = sid;
        bus.branch_flag   = br;
        bus.branch_target = bt;
        bus.flush         = fl;
        bus.flush_pc      = fp;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input int row, input logic en, input logic [31:0] pc,
                              input logic [31:0] ipc, input logic [31:0] iinst,
                              input logic iv, input logic ie);
        chk("rom_en",    row, {31'b0, bus.rom_en},    {31'b0, en});
        chk("rom_addr",  row, bus.rom_addr,           pc);
        chk("id_pc",     row, bus.id_pc,              ipc);
        chk("id_inst",   row, bus.id_inst,            iinst);
        chk("id_valid",  row, {31'b0, bus.id_valid},  {31'b0, iv});
        chk("fetch_err", row, {31'b0, bus.fetch_err}, {31'b0, ie});
    endtask

    initial begin
        rst = 1'b1;
        bus.stall_if = 1'b0; bus.stall_id = 1'b0; bus.branch_flag = 1'b0;
        bus.branch_target = '0; bus.flush = 1'b0; bus.flush_pc = '0;

        //   r sif sid br bt            fl fp             en pc            id_pc         id_inst           v  e
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        N,                0, 0);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        N,                0, 0);
        add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        N,                0, 0);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        N,                0, 0);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        32'h0,        rv(32'h0),        1, 0);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'h4,        rv(32'h4),        1, 0);
        add(0, 0, 0, 1, 32'h40,       0, 32'h0,        1, 32'h40,       32'h8,        rv(32'h8),        1, 0);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h44,       32'h40,       rv(32'h40),       1, 0);
        add(0, 0, 0, 1, 32'h10,       0, 32'h0,        1, 32'h10,       32'h44,       rv(32'h44),       1, 0);
        add(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       32'h44,       N,                0, 0);
        add(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       32'h44,       N,                0, 0);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h14,       32'h10,       rv(32'h10),       1, 0);
        add(0, 1, 1, 0, 32'h0,        0, 32'h0,        1, 32'h14,       32'h10,       rv(32'h10),       1, 0);
        add(0, 0, 1, 0, 32'h0,        0, 32'h0,        1, 32'h18,       32'h10,       rv(32'h10),       1, 0);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h1C,       32'h18,       rv(32'h18),       1, 0);
        add(0, 1, 0, 1, 32'h80,       1, 32'h20,       1, 32'h20,       32'h18,       N,                0, 0);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h24,       32'h20,       rv(32'h20),       1, 0);
        add(0, 1, 0, 1, 32'h80,       0, 32'h0,        1, 32'h24,       32'h20,       N,                0, 0);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h28,       32'h24,       rv(32'h24),       1, 0);
        add(0, 0, 0, 1, 32'h202,      0, 32'h0,        1, 32'h202,      32'h28,       rv(32'h28),       1, 0);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h206,      32'h202,      N,                1, 1);
        add(0, 0, 0, 1, 32'h200,      0, 32'h0,        1, 32'h200,      32'h206,      N,                1, 1);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h204,      32'h200,      N,                1, 1);
        add(0, 0, 0, 0, 32'h0,        1, 32'h1FC,      1, 32'h1FC,      32'h200,      N,                0, 0);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h200,      32'h1FC,      rv(32'h1FC),      1, 0);
        add(0, 0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h1FC,     N,                0, 0);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'hFFFF_FFFC, N,               1, 1);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        32'h0,        rv(32'h0),        1, 0);
        add(0, 0, 0, 1, 32'h1C,       0, 32'h0,        1, 32'h1C,       32'h4,        rv(32'h4),        1, 0);
        add(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        N,                0, 0);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        N,                0, 0);
        add(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        32'h0,        rv(32'h0),        1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].sif, vecs[i].sid, vecs[i].br, vecs[i].bt, vecs[i].fl, vecs[i].fp);
            check_outs(i, vecs[i].en, vecs[i].pc, vecs[i].ipc, vecs[i].iinst, vecs[i].iv, vecs[i].ie);
        end

        // Flush overrides a decode hold: bubble, id_pc kept, PC redirected
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
        check_outs(100, 1'b1, 32'h8, 32'h4, rv(32'h4), 1'b1, 1'b0);
        drive(0, 0, 1, 0, 32'h0, 1, 32'h100);
        check_outs(101, 1'b1, 32'h100, 32'h4, N, 1'b0, 1'b0);

        // Reset discards a simultaneous branch
        drive(1, 0, 0, 1, 32'h40, 0, 32'h0);
        check_outs(102, 1'b0, 32'h0, 32'h0, N, 1'b0, 1'b0);

        // Flush on the reset-release edge is ignored: PC not advanced or redirected
        drive(0, 0, 0, 0, 32'h0, 1, 32'h80);
        check_outs(103, 1'b1, 32'h0, 32'h0, N, 1'b0, 1'b0);
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
        check_outs(104, 1'b1, 32'h4, 32'h0, rv(32'h0), 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
